mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Multi-cycle load/store unit between execute and write-back. Takes the effective
//  address and store data from execute, runs one handshake transaction on the data
//  bus, and sign/zero-extends load data into data_mem, which feeds write-back.
//  Raises stall while an access is outstanding so the core freezes its PC and state.
// PARAMETERS
//  TIMEOUT  16  max cycles in REQ waiting for bus_ready before aborting with mem_err
// PORTS
//  clk         in   1   core clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  inst_valid  in   1   instruction in this stage is valid
//  operation   in   7   opcode; load=7'b0000011, store=7'b0100011, others ignored
//  funct3      in   3   access size/sign (RV32I encoding)
//  data_addr   in   32  effective address from execute
//  data_store  in   32  rs2 value for stores
//  bus_req     out  1   transaction request, held until bus_ready
//  bus_we      out  1   1=write, 0=read
//  bus_addr    out  32  word-aligned address {addr[31:2],2'b00}
//  bus_wdata   out  32  lane-replicated store data
//  bus_strb    out  4   byte-enable for writes, 4'b0000 for reads
//  bus_ready   in   1   slave accepts/completes transaction this cycle
//  bus_rdata   in   32  read data, valid when bus_ready & ~bus_we
//  data_mem    out  32  extended load result to write-back
//  stall       out  1   hold pipeline; access not yet complete
//  mem_err     out  1   one-cycle pulse: misaligned, illegal funct3 or timeout
// BEHAVIOUR
//  Reset: state=IDLE; bus_req, bus_we, bus_strb, bus_addr, bus_wdata, data_mem,
//   mem_err, timeout counter = 0. Reset mid-transaction drops bus_req immediately.
//  FSM IDLE -> REQ -> DONE -> IDLE.
//  IDLE: mem op = inst_valid & (load|store). stall = mem op (combinational).
//   Legal op: latch addr/size/sign/we/wdata/strb, -> REQ.
//   Illegal op (misaligned: half with addr[0]=1, word with addr[1:0]!=0; load
//   funct3 011/110/111; store funct3 >=011): no bus access, mem_err=1 next cycle, -> DONE.
//   Non-memory op: stall=0, stay IDLE.
//  REQ: bus_req=1, stall=1, outputs stable. Counter increments each cycle.
//   bus_ready=1: read latches extended bus_rdata into data_mem; -> DONE.
//   Counter reaches TIMEOUT-1 with no ready: drop req, mem_err=1, data_mem=0, -> DONE.
//   bus_ready in the same cycle as the timeout: ready wins, no error.
//  DONE: stall=0 for exactly one cycle (pipeline advances), bus_req=0, -> IDLE.
//   mem_err is high only in DONE.
//  Latency: legal access = 1 (IDLE) + N wait cycles + 1 (DONE); minimum 3 cycles
//   with bus_ready already high on the first REQ cycle.
//  Store lanes: SB strb=4'b0001<<addr[1:0], wdata={4{d[7:0]}};
//   SH strb=addr[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}; SW strb=4'b1111, wdata=d.
//  Load extract: byte=rdata[8*addr[1:0]+:8], half=rdata[16*addr[1]+:16];
//   LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
//  data_mem is held unchanged by stores, non-memory ops and illegal ops; it changes
//   only on a completed load or on a timeout (cleared to 0).
//  Inputs are sampled only in IDLE; changes during REQ or DONE are ignored.
// TESTING
//  LW addr=0x100, ready on 1st REQ cycle, rdata=0xDEADBEEF -> data_mem=0xDEADBEEF,
//   stall high 2 cycles, total 3 cycles.
//  LB addr=0x103 rdata=0x80FFFFFF -> data_mem=0xFFFFFF80; LBU same -> 0x00000080;
//   LHU addr=0x102 -> 0x000080FF.
//  SB addr=0x201 data=0x000000AB -> bus_we=1, bus_addr=0x200, strb=4'b0010,
//   wdata=0xABABABAB; data_mem unchanged.
//  LH addr=0x101 -> no bus_req, mem_err pulse in DONE, stall released after 2 cycles.
//  Load with bus_ready held low -> mem_err after TIMEOUT cycles, data_mem=0.
//   Same load with ready on cycle TIMEOUT-1 -> completes normally, no mem_err.
//  Assert rst during REQ -> bus_req=0 asynchronously; after release FSM is in IDLE
//   and the next LW completes normally.

Source files
------------

// File: rtl/mem_access.sv
// rtl/mem_access.sv - multi-cycle load/store unit between execute and write-back
// One bus handshake per memory op; stall holds the core until the DONE cycle.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inst_valid,
  input  logic [6:0]  i_operation,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_store,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_strb,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_data_mem,
  output logic        o_stall,
  output logic        o_mem_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_we;
  logic [31:0]   r_addr;
  logic [2:0]    r_funct3;
  logic [31:0]   r_wdata;
  logic [3:0]    r_strb;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_data_mem;
  logic          r_mem_err;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_mem_op;
  logic        w_misalign;
  logic        w_bad_f3;
  logic        w_illegal;
  logic        w_stall;
  logic [3:0]  w_st_strb;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_val;
  logic        w_timeout;

  assign w_is_load  = (i_operation == OP_LOAD);
  assign w_is_store = (i_operation == OP_STORE);
  assign w_mem_op   = i_inst_valid & (w_is_load | w_is_store);

  always_comb begin
    w_misalign = 1'b0;
    case (i_funct3[1:0])
      2'b01:   w_misalign = i_data_addr[0];
      2'b10:   w_misalign = |i_data_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  // Loads allow 000,001,010,100,101; stores allow only 000..010.
  assign w_bad_f3  = w_is_store ? (i_funct3 >= 3'b011)
                                : ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11));
  assign w_illegal = w_misalign | w_bad_f3;

  always_comb begin
    w_st_strb  = 4'b1111;
    w_st_wdata = i_data_store;
    case (i_funct3[1:0])
      2'b00: begin
        w_st_strb  = 4'b0001 << i_data_addr[1:0];
        w_st_wdata = {4{i_data_store[7:0]}};
      end
      2'b01: begin
        w_st_strb  = i_data_addr[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{i_data_store[15:0]}};
      end
      default: begin
        w_st_strb  = 4'b1111;
        w_st_wdata = i_data_store;
      end
    endcase
  end

  assign w_ld_byte = i_bus_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_ld_half = i_bus_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_ld_val = i_bus_rdata;
    case (r_funct3)
      3'b000:  w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_val = {24'b0, w_ld_byte};
      3'b101:  w_ld_val = {16'b0, w_ld_half};
      default: w_ld_val = i_bus_rdata;
    endcase
  end

  assign w_timeout = (r_cnt == CNT_LAST);

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_mem_op;
        if (w_mem_op) begin
          w_next = w_illegal ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (i_bus_ready || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_addr     <= 32'b0;
      r_funct3   <= 3'b0;
      r_wdata    <= 32'b0;
      r_strb     <= 4'b0;
      r_cnt      <= '0;
      r_data_mem <= 32'b0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_mem_op) begin
            if (w_illegal) begin
              r_mem_err <= 1'b1;
            end else begin
              r_we     <= w_is_store;
              r_addr   <= i_data_addr;
              r_funct3 <= i_funct3;
              r_wdata  <= w_is_store ? w_st_wdata : 32'b0;
              r_strb   <= w_is_store ? w_st_strb : 4'b0000;
            end
          end
        end
        S_REQ: begin
          // A ready arriving on the last allowed cycle still completes normally.
          if (i_bus_ready) begin
            r_cnt <= '0;
            if (!r_we) begin
              r_data_mem <= w_ld_val;
            end
          end else if (w_timeout) begin
            r_cnt      <= '0;
            r_mem_err  <= 1'b1;
            r_data_mem <= 32'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign o_bus_req   = (r_state == S_REQ);
  assign o_bus_we    = r_we;
  assign o_bus_addr  = {r_addr[31:2], 2'b00};
  assign o_bus_wdata = r_wdata;
  assign o_bus_strb  = r_strb;
  assign o_data_mem  = r_data_mem;
  assign o_stall     = w_stall;
  assign o_mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
// Transaction-level model builds per-cycle expectations; one negedge process compares.
module tb_mem_access;

  localparam int TIMEOUT = 16;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_inst_valid;
  logic [6:0]  i_operation;
  logic [2:0]  i_funct3;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_store;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_strb;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic [31:0] o_data_mem;
  logic        o_stall;
  logic        o_mem_err;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_inst_valid (i_inst_valid),
    .i_operation  (i_operation),
    .i_funct3     (i_funct3),
    .i_data_addr  (i_data_addr),
    .i_data_store (i_data_store),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .o_bus_strb   (o_bus_strb),
    .i_bus_ready  (i_bus_ready),
    .i_bus_rdata  (i_bus_rdata),
    .o_data_mem   (o_data_mem),
    .o_stall      (o_stall),
    .o_mem_err    (o_mem_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          tag;
    logic        req;
    logic        stall;
    logic        err;
    logic [31:0] dm;
    bit          chk_bus;
    bit          chk_wdata;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          lit_dm_en;
    logic [31:0] lit_dm;
    bit          lit_bus_en;
    logic [31:0] lit_addr;
    logic [31:0] lit_wdata;
    logic [3:0]  lit_strb;
  } exp_t;

  exp_t        q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          tag = 0;
  logic [31:0] model_dm = 32'b0;

  task automatic chk(input int t, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL t%0d %s actual=%h required=%h", t, nm, act, exp);
  endtask

  always @(negedge i_clk) begin : compare
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.tag, "bus_req", {31'b0, o_bus_req}, {31'b0, e.req});
      chk(e.tag, "stall", {31'b0, o_stall}, {31'b0, e.stall});
      chk(e.tag, "mem_err", {31'b0, o_mem_err}, {31'b0, e.err});
      chk(e.tag, "data_mem", o_data_mem, e.dm);
      if (e.chk_bus) begin
        chk(e.tag, "bus_we", {31'b0, o_bus_we}, {31'b0, e.we});
        chk(e.tag, "bus_addr", o_bus_addr, e.addr);
        chk(e.tag, "bus_strb", {28'b0, o_bus_strb}, {28'b0, e.strb});
      end
      if (e.chk_wdata) chk(e.tag, "bus_wdata", o_bus_wdata, e.wdata);
      if (e.lit_dm_en) chk(e.tag, "lit_data_mem", o_data_mem, e.lit_dm);
      if (e.lit_bus_en) begin
        chk(e.tag, "lit_bus_addr", o_bus_addr, e.lit_addr);
        chk(e.tag, "lit_bus_strb", {28'b0, o_bus_strb}, {28'b0, e.lit_strb});
        chk(e.tag, "lit_bus_wdata", o_bus_wdata, e.lit_wdata);
      end
    end
  end

  function automatic exp_t base();
    exp_t e;
    e = '{default: 0};
    e.tag = tag;
    e.dm  = model_dm;
    return e;
  endfunction

  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    int nbytes;
    if (f3[1:0] == 2'b11) return 1'b0;
    if (st && f3 > 3'd2) return 1'b0;
    if (!st && (f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
    nbytes = 1 << f3[1:0];
    if ((addr % nbytes) != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_lanes(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] d, output logic [3:0] s, output logic [31:0] w);
    if (!st) begin
      s = 4'b0;
      w = 32'b0;
    end else if (f3[1:0] == 2'b00) begin
      s = 4'(1 << addr[1:0]);
      w = 32'(d[7:0]) * 32'h01010101;
    end else if (f3[1:0] == 2'b01) begin
      s = 4'(3 << (2 * addr[1]));
      w = 32'(d[15:0]) * 32'h00010001;
    end else begin
      s = 4'hF;
      w = d;
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int off;
    off = int'(addr[1:0]);
    v = rd;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic nonmem(input logic v, input logic [6:0] op);
    exp_t e;
    tag++;
    i_inst_valid = v;
    i_operation  = op;
    i_data_addr  = $urandom;
    e = base();
    step(e);
    i_inst_valid = 1'b0;
  endtask

  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int wait_n,
                        input bit ldm_en, input logic [31:0] ldm,
                        input bit lbus_en, input logic [31:0] laddr, input logic [3:0] lstrb,
                        input logic [31:0] lwdata);
    exp_t e;
    int n_req;
    bit ok;
    logic [3:0] s;
    logic [31:0] w;
    tag++;
    ok = model_legal(st, f3, addr);
    model_lanes(st, f3, addr, sdata, s, w);
    i_inst_valid = 1'b1;
    i_operation  = st ? OP_STORE : OP_LOAD;
    i_funct3     = f3;
    i_data_addr  = addr;
    i_data_store = sdata;
    i_bus_ready  = 1'b0;
    e = base();
    e.stall = 1'b1;
    step(e);
    // Changes after the IDLE cycle must be ignored.
    i_operation  = OP_LOAD;
    i_data_addr  = $urandom;
    i_data_store = $urandom;
    i_funct3     = 3'($urandom);
    if (!ok) begin
      e = base();
      e.err = 1'b1;
      step(e);
    end else begin
      n_req = (wait_n < 0) ? TIMEOUT : wait_n + 1;
      for (int i = 0; i < n_req; i++) begin
        i_bus_ready = (i == wait_n);
        i_bus_rdata = (i == wait_n) ? rdata : $urandom;
        e = base();
        e.req = 1'b1;
        e.stall = 1'b1;
        e.chk_bus = 1'b1;
        e.we = st;
        e.addr = addr & ~32'h3;
        e.strb = s;
        e.wdata = w;
        e.chk_wdata = st;
        e.lit_bus_en = lbus_en;
        e.lit_addr = laddr;
        e.lit_strb = lstrb;
        e.lit_wdata = lwdata;
        step(e);
      end
      i_bus_ready = 1'b0;
      if (wait_n < 0) begin
        model_dm = 32'b0;
        e = base();
        e.err = 1'b1;
      end else begin
        if (!st) model_dm = model_ext(f3, addr, rdata);
        e = base();
      end
      e.lit_dm_en = ldm_en;
      e.lit_dm = ldm;
      step(e);
    end
    i_inst_valid = 1'b0;
    i_operation  = 7'b0;
  endtask

  task automatic reset_mid_req();
    exp_t e;
    tag++;
    i_inst_valid = 1'b1;
    i_operation  = OP_LOAD;
    i_funct3     = 3'b010;
    i_data_addr  = 32'h180;
    i_bus_ready  = 1'b0;
    e = base();
    e.stall = 1'b1;
    step(e);
    i_inst_valid = 1'b0;
    i_rst = 1'b1;
    model_dm = 32'b0;
    e = base();
    e.chk_bus = 1'b1;
    e.chk_wdata = 1'b1;
    step(e);
    i_rst = 1'b0;
    e = base();
    step(e);
  endtask

  initial begin : main
    exp_t e;
    i_rst = 1'b1;
    i_inst_valid = 1'b0;
    i_operation = 7'b0;
    i_funct3 = 3'b0;
    i_data_addr = 32'b0;
    i_data_store = 32'b0;
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'b0;
    @(posedge i_clk);
    #1;
    e = base();
    e.chk_bus = 1'b1;
    e.chk_wdata = 1'b1;
    step(e);
    step(e);
    i_rst = 1'b0;

    nonmem(1'b1, OP_ALU);
    nonmem(1'b0, OP_LOAD);
    access(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    access(0, 3'b000, 32'h103, 0, 32'h80FFFFFF, 0, 1, 32'hFFFFFF80, 0, 0, 0, 0);
    access(0, 3'b100, 32'h103, 0, 32'h80FFFFFF, 1, 1, 32'h00000080, 0, 0, 0, 0);
    access(0, 3'b101, 32'h102, 0, 32'h80FFFFFF, 0, 1, 32'h000080FF, 0, 0, 0, 0);
    access(0, 3'b001, 32'h102, 0, 32'h80FF1234, 2, 1, 32'hFFFF80FF, 0, 0, 0, 0);
    access(1, 3'b000, 32'h201, 32'h000000AB, 0, 0, 1, 32'hFFFF80FF, 1, 32'h200, 4'b0010, 32'hABABABAB);
    access(1, 3'b001, 32'h202, 32'h1234CDEF, 0, 1, 0, 0, 1, 32'h200, 4'b1100, 32'hCDEFCDEF);
    access(1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 3, 0, 0, 0, 0, 0, 0);
    nonmem(1'b1, OP_ALU);
    access(0, 3'b001, 32'h101, 0, 0, 0, 1, 32'hFFFF80FF, 0, 0, 0, 0);
    access(0, 3'b010, 32'h102, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    access(1, 3'b011, 32'h200, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0);
    access(0, 3'b110, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    access(0, 3'b010, 32'h400, 0, 0, -1, 1, 32'h0, 0, 0, 0, 0);
    access(0, 3'b010, 32'h400, 0, 32'h13579BDF, TIMEOUT - 1, 1, 32'h13579BDF, 0, 0, 0, 0);
    access(0, 3'b000, 32'h401, 0, 32'h00007F00, 0, 1, 32'h0000007F, 0, 0, 0, 0);
    reset_mid_req();
    access(0, 3'b010, 32'h104, 0, 32'h0BADF00D, 0, 1, 32'h0BADF00D, 0, 0, 0, 0);
    nonmem(1'b0, OP_STORE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
